// File: rtl/uart_rx.sv
// uart_rx: serial receiver for the host-to-FPGA command link.
// Frame: start(0), data MSB first, optional even parity, C_UART_STOP stop bits (1).
// The line is synchronized into the clock domain and sampled at the mid-point of
// each bit. One valid pulse is issued per completed frame, together with the word
// and its parity/framing error flags.
module uart_rx #(
    parameter int C_CLK_FRQ         = 100000000,
    parameter int C_UART_RATE       = 1000000,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_UART_PARITY     = 1,
    parameter int C_UART_STOP       = 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         rx,
    output logic [C_UART_DATA_WIDTH-1:0] data,
    output logic                         valid,
    output logic                         busy,
    output logic                         parity_err,
    output logic                         frame_err
);

    localparam int C_PERIOD = C_CLK_FRQ / C_UART_RATE;
    localparam int CW       = $clog2(C_PERIOD);
    localparam int BMAX     = (C_UART_DATA_WIDTH > C_UART_STOP) ? C_UART_DATA_WIDTH : C_UART_STOP;
    localparam int BW       = $clog2(BMAX + 1);

    localparam logic [CW-1:0] LAST_FULL = CW'(C_PERIOD - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(C_PERIOD / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(C_UART_DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(C_UART_STOP - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic                         sync1;
    logic                         rs;
    logic [2:0]                   state;
    logic [CW-1:0]                cnt;
    logic [BW-1:0]                bcnt;
    logic [C_UART_DATA_WIDTH-1:0] shift;
    logic                         perr;
    logic                         ferr;
    logic                         tick_full;
    logic                         tick_half;

    assign tick_full = (cnt == LAST_FULL);
    assign tick_half = (cnt == LAST_HALF);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1 <= 1'b1;
            rs    <= 1'b1;
        end else begin
            sync1 <= rx;
            rs    <= sync1;
        end
    end

    // busy follows the state one clock late: high whenever the FSM is not idle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy <= 1'b0;
        end else begin
            busy <= (state != S_IDLE);
        end
    end

    // Receive FSM: mid-bit sampling, shift-in, error accumulation and word hand-off.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bcnt       <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    bcnt <= '0;
                    perr <= 1'b0;
                    ferr <= 1'b0;
                    if (!rs) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick_half) begin
                        cnt <= '0;
                        // A line back high at mid start bit was only a glitch.
                        state <= rs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_full) begin
                        cnt   <= '0;
                        shift <= C_UART_DATA_WIDTH'({shift, rs});
                        if (bcnt == LAST_DATA) begin
                            bcnt  <= '0;
                            state <= (C_UART_PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick_full) begin
                        cnt   <= '0;
                        perr  <= rs ^ (^shift);
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_full) begin
                        cnt  <= '0;
                        ferr <= ferr | ~rs;
                        if (bcnt == LAST_STOP) begin
                            bcnt  <= '0;
                            state <= S_DONE;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    data       <= shift;
                    parity_err <= perr;
                    frame_err  <= ferr;
                    valid      <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
